hazard_forward_unit: RTL



---
 rtl/hazard_forward_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the decode/execute boundary.
// Tracks DEPTH post-execute producers and issues registered forward selects aligned with execute.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 2,
  parameter int MULT_LAT   = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_src_a,
  input  logic [REG_ADDR_W-1:0] dec_src_b,
  input  logic                  dec_use_a,
  input  logic                  dec_use_b,
  input  logic [REG_ADDR_W-1:0] dec_dest,
  input  logic                  dec_has_wb,
  input  logic                  dec_is_mult,
  input  logic                  redirect,
  output logic                  dec_accept,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic                  exe_valid,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Handshake: the decode instruction transfers into execute at the rising edge where
  // dec_valid and dec_accept are both high; a valid instruction that is not accepted
  // either waits (stall) or is discarded by the decoder (redirect squash).

  logic                  eValid  [1:DEPTH];
  logic [REG_ADDR_W-1:0] eDest   [1:DEPTH];
  logic                  eHasWb  [1:DEPTH];
  logic                  eIsMult [1:DEPTH];

  logic [SEL_W-1:0] candA;
  logic [SEL_W-1:0] candB;
  logic             readyA;
  logic             readyB;

  // Scanning oldest to youngest lets the youngest match overwrite, including its readiness.
  always_comb begin
    candA  = '0;
    candB  = '0;
    readyA = 1'b1;
    readyB = 1'b1;
    for (int j = DEPTH; j >= 1; j--) begin
      if (dec_use_a && eValid[j] && eHasWb[j] && (eDest[j] == dec_src_a)) begin
        candA  = SEL_W'(j);
        readyA = !eIsMult[j] || (j >= MULT_LAT);
      end
      if (dec_use_b && eValid[j] && eHasWb[j] && (eDest[j] == dec_src_b)) begin
        candB  = SEL_W'(j);
        readyB = !eIsMult[j] || (j >= MULT_LAT);
      end
    end
  end

  assign stall      = dec_valid & ~redirect & (~readyA | ~readyB);
  assign dec_accept = dec_valid & ~stall & ~redirect;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int j = 1; j <= DEPTH; j++) begin
        eValid[j]  <= 1'b0;
        eDest[j]   <= '0;
        eHasWb[j]  <= 1'b0;
        eIsMult[j] <= 1'b0;
      end
      fwd_sel_a <= '0;
      fwd_sel_b <= '0;
      exe_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // The oldest entry falls off: its writeback is done and the bank is current.
      for (int j = 2; j <= DEPTH; j++) begin
        eValid[j]  <= eValid[j-1];
        eDest[j]   <= eDest[j-1];
        eHasWb[j]  <= eHasWb[j-1];
        eIsMult[j] <= eIsMult[j-1];
      end
      eValid[1]  <= dec_accept;
      eDest[1]   <= dec_dest;
      eHasWb[1]  <= dec_has_wb;
      eIsMult[1] <= dec_is_mult;
      exe_valid  <= dec_accept;
      fwd_sel_a  <= dec_accept ? candA : '0;
      fwd_sel_b  <= dec_accept ? candB : '0;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
